// File: rtl/axi128_pkg.sv
// Shared types and constants for the 128-bit AXI copy engine.
// The 4 KB page check helper is used only when AXI_DMA128_RESP_CHECK_EN is defined.
package axi128_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 40;
  localparam int ID_W   = 8;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } dma_state_e;

  // beat_off is address bits [11:4]; true when the burst runs past the page end.
  function automatic logic crosses_4k(input logic [7:0] beat_off, input logic [3:0] len);
    logic [12:0] start_b;
    logic [12:0] nbytes;
    start_b = {1'b0, beat_off, 4'b0000};
    nbytes  = {4'b0000, ({1'b0, len} + 5'd1), 4'b0000};
    return (start_b + nbytes) > 13'h1000;
  endfunction

endpackage

// File: rtl/axi_dma128_buf.sv
// 16 x 128-bit beat buffer: one write port filled from R, one registered read port feeding W.
module axi_dma128_buf
  import axi128_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [16];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_dma128_master.sv
// Single-channel AXI 128-bit copy engine: one INCR read burst into a local buffer, then one INCR write burst.
// Optional response/ID/rlast/4 KB checking and the err port are built when AXI_DMA128_RESP_CHECK_EN is defined.
module axi_dma128_master
  import axi128_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID = 8'h5A
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [3:0]        cmd_len,
  output logic              busy,
  output logic              done,
`ifdef AXI_DMA128_RESP_CHECK_EN
  output logic              err,
`endif
  output logic [ADDR_W-1:0] araddr_m0,
  output logic [7:0]        arlen_m0,
  output logic [2:0]        arsize_m0,
  output logic [1:0]        arburst_m0,
  output logic [ID_W-1:0]   arid_m0,
  output logic [3:0]        arcache_m0,
  output logic [2:0]        arprot_m0,
  output logic              arvalid_m0,
  input  logic              arready_m0,
  input  logic [DATA_W-1:0] rdata_m0,
  input  logic [ID_W-1:0]   rid_m0,
  input  logic [1:0]        rresp_m0,
  input  logic              rlast_m0,
  input  logic              rvalid_m0,
  output logic              rready_m0,
  output logic [ADDR_W-1:0] awaddr_m0,
  output logic [7:0]        awlen_m0,
  output logic [2:0]        awsize_m0,
  output logic [1:0]        awburst_m0,
  output logic [ID_W-1:0]   awid_m0,
  output logic [3:0]        awcache_m0,
  output logic [2:0]        awprot_m0,
  output logic              awvalid_m0,
  input  logic              awready_m0,
  output logic [DATA_W-1:0] wdata_m0,
  output logic [DATA_W/8-1:0] wstrb_m0,
  output logic [ID_W-1:0]   wid_m0,
  output logic              wlast_m0,
  output logic              wvalid_m0,
  input  logic              wready_m0,
  input  logic [ID_W-1:0]   bid_m0,
  input  logic [1:0]        bresp_m0,
  input  logic              bvalid_m0,
  output logic              bready_m0
);

  dma_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        len_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic              done_q;
  logic              accept, cnt_last, r_beat, w_beat, b_beat;
  logic              rd_en;
  logic [3:0]        rd_addr;

  assign accept   = (state_q == ST_IDLE) && cmd_valid;
  assign cnt_last = (cnt_q == len_q);
  assign r_beat   = (state_q == ST_R) && rvalid_m0;
  assign w_beat   = (state_q == ST_W) && wready_m0;
  assign b_beat   = (state_q == ST_B) && bvalid_m0;

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= b_beat;
      if (accept) begin
        src_q <= {cmd_src[ADDR_W-1:4], 4'b0000};
        dst_q <= {cmd_dst[ADDR_W-1:4], 4'b0000};
        len_q <= cmd_len;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    arvalid_m0 = 1'b0;
    rready_m0  = 1'b0;
    awvalid_m0 = 1'b0;
    wvalid_m0  = 1'b0;
    wlast_m0   = 1'b0;
    bready_m0  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = ST_AR;
          cnt_d   = '0;
        end
      end
      ST_AR: begin
        arvalid_m0 = 1'b1;
        if (arready_m0) state_d = ST_R;
      end
      ST_R: begin
        // The beat count, not rlast, ends the read phase.
        rready_m0 = 1'b1;
        if (rvalid_m0) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_AW;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_AW: begin
        awvalid_m0 = 1'b1;
        if (awready_m0) state_d = ST_W;
      end
      ST_W: begin
        wvalid_m0 = 1'b1;
        wlast_m0  = cnt_last;
        if (wready_m0) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_B: begin
        bready_m0 = 1'b1;
        if (bvalid_m0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payloads are zero outside their valid phase so every output idles at 0.
  assign araddr_m0  = arvalid_m0 ? src_q : '0;
  assign arlen_m0   = arvalid_m0 ? {4'b0000, len_q} : '0;
  assign arsize_m0  = arvalid_m0 ? SIZE_16B : '0;
  assign arburst_m0 = arvalid_m0 ? BURST_INCR : '0;
  assign arid_m0    = arvalid_m0 ? AXI_ID : '0;
  assign arcache_m0 = '0;
  assign arprot_m0  = '0;

  assign awaddr_m0  = awvalid_m0 ? dst_q : '0;
  assign awlen_m0   = awvalid_m0 ? {4'b0000, len_q} : '0;
  assign awsize_m0  = awvalid_m0 ? SIZE_16B : '0;
  assign awburst_m0 = awvalid_m0 ? BURST_INCR : '0;
  assign awid_m0    = awvalid_m0 ? AXI_ID : '0;
  assign awcache_m0 = '0;
  assign awprot_m0  = '0;

  assign wstrb_m0 = wvalid_m0 ? {(DATA_W/8){1'b1}} : '0;
  assign wid_m0   = wvalid_m0 ? AXI_ID : '0;
  assign done     = done_q;

  // Prefetch the next beat on an accepted W beat so wdata always comes from a flop.
  assign rd_addr = w_beat ? (cnt_q + 4'd1) : cnt_q;
  assign rd_en   = (state_q == ST_AW) || ((state_q == ST_W) && !(w_beat && cnt_last));

  axi_dma128_buf u_buf (
    .clk     (pll_core_cpuclk),
    .rst_n   (pad_cpu_rst_b),
    .wr_en   (r_beat),
    .wr_addr (cnt_q),
    .wr_data (rdata_m0),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (wdata_m0)
  );

`ifdef AXI_DMA128_RESP_CHECK_EN
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    if (r_beat && ((rresp_m0 != RESP_OKAY) || (rid_m0 != AXI_ID) || (rlast_m0 != cnt_last))) begin
      err_set = 1'b1;
    end
    if (b_beat && ((bresp_m0 != RESP_OKAY) || (bid_m0 != AXI_ID))) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= crosses_4k(cmd_src[11:4], cmd_len) || crosses_4k(cmd_dst[11:4], cmd_len);
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{cmd_src[3:0], cmd_dst[3:0], rid_m0, rresp_m0, rlast_m0, bid_m0, bresp_m0};

endmodule

// File: doc/axi_dma128_master.md
# axi_dma128_master

Single-channel AXI 128-bit copy engine: accepts one copy command, reads an INCR burst of up to 16 beats from a source address into a local buffer, then writes it as one INCR burst to a destination address. It is the initiator counterpart of the 128-bit AXI slave memory model. In the C908 test environment it drives the slave's `_s0` port set to preload, move and check memory without involving the core.

## Interface
- `AXI_ID`, default 8'h5A: constant value driven on arid/awid/wid.
- `pll_core_cpuclk` in 1: clock, all logic on rising edge.
- `pad_cpu_rst_b` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake; `cmd_ready` = state IDLE.
- `cmd_src`, `cmd_dst` in 40: byte addresses; bits [3:0] ignored and forced to 0.
- `cmd_len` in 4: beats−1, range 0..15.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse on the B handshake.
- `err` out 1: sticky error flag, present only with the config macro, cleared on command accept.
- AR: `araddr_m0` 40, `arlen_m0` 8, `arsize_m0` 3, `arburst_m0` 2, `arid_m0` 8, `arcache_m0` 4, `arprot_m0` 3, `arvalid_m0` out; `arready_m0` in.
- R: `rdata_m0` 128, `rid_m0` 8, `rresp_m0` 2, `rlast_m0` 1, `rvalid_m0` in; `rready_m0` out.
- AW: mirrors AR with the `aw` prefix; `awready_m0` in.
- W: `wdata_m0` 128, `wstrb_m0` 16, `wid_m0` 8, `wlast_m0`, `wvalid_m0` out; `wready_m0` in.
- B: `bid_m0` 8, `bresp_m0` 2, `bvalid_m0` in; `bready_m0` out.

## Operation
- States: IDLE, AR, R, AW, W, B.
- IDLE
  - On `cmd_valid`, latch src, dst and len.
  - Clear the beat counter and `err`.
  - Go to AR.
- AR
  - `arvalid_m0`=1; araddr = src, arlen = {4'b0, len}, arsize = 3'b100, arburst = 2'b01, arcache = 4'b0, arprot = 3'b0.
  - On `arready_m0`, go to R.
- R
  - `rready_m0`=1.
  - On each rvalid beat, write rdata to buffer[cnt] and increment cnt.
  - On the beat where cnt==len, clear cnt and go to AW.
- AW
  - Same fields as AR, with awaddr = dst.
  - On `awready_m0`, go to W.
- W
  - `wvalid_m0`=1; wdata = buffer[cnt], wstrb = 16'hFFFF, `wlast_m0` = (cnt==len).
  - Increment cnt on `wready_m0`.
  - On the last beat, go to B.
- B
  - `bready_m0`=1.
  - On `bvalid_m0`, pulse `done` and go to IDLE.
- Handshake rules
  - A valid, once asserted, stays high with stable payload until ready.
  - Valid never depends combinationally on ready.
- Boundaries
  - 4 KB crossing is not split; the caller guarantees src/dst + 16·(len+1) stays within one 4 KB page.
  - cnt is 4 bits, so len=15 ends with cnt==15 and no wrap beyond the buffer.
  - `rlast_m0` is not used for termination; the count is authoritative.
  - `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- Reset mid-operation
  - All valids, readies, `busy`, `done` and `err` drop to 0 immediately; state goes to IDLE.
  - Buffer contents are undefined and are not cleared.

## Timing
- Reset values: every output is 0 (addresses, len, size, burst, id, data, strb included), except `cmd_ready`=1.
- Command accepted at edge N → `arvalid_m0` high in cycle N+1.
- R last beat at edge M → `awvalid_m0` high in cycle M+1.
- W last beat at edge K → `bready_m0` high in cycle K+1.
- B handshake at edge J → `done` high in cycle J+1, together with `cmd_ready`=1.
- Ready held high in the AR/AW states gives zero wait; minimum command time is 5 + 2·(len+1) cycles.
- `wdata_m0` is registered: the buffer is read with `wdata` presented from a flop, with no combinational path from `wready_m0` to `wdata_m0`.

## Configuration
- `AXI_DMA128_RESP_CHECK_EN`
  - Defined:
    - `err` is set on any rresp≠0, bresp≠0, rid/bid≠AXI_ID, `rlast_m0` mismatching cnt==len, or cmd_src/cmd_dst+16·(len+1) crossing a 4 KB boundary.
    - The transfer always completes; `err` remains set until the next accept.
  - Undefined: the `err` port is absent, responses are ignored, and no checker logic is synthesized.

## Structure
- Package `axi128_pkg` holds:
  - the state enum;
  - the constants BURST_INCR=2'b01, SIZE_16B=3'b100, RESP_OKAY=2'b00;
  - the data/address/id width localparams (128/40/8).
- Sub-module `axi_dma128_buf`: a 16×128 flop array with one write port (R state) and one registered read port (W state), 4-bit addresses.

## Test plan
- Single beat: src=0x1000, dst=0x2000, len=0, slave preloaded 0x1000=128'hA5…A5 → one R beat, one W beat with wlast=1, `done` pulse, 0x2000 reads back A5…A5.
- Full burst: len=15, src=0x0, dst=0x800 with incrementing pattern → arlen=awlen=8'h0F, 16 W beats in order, wlast only on beat 15, memory compare passes.
- Backpressure: slave deasserts arready/awready/wready randomly 0–3 cycles → payloads stable while valid is high, no beat lost or duplicated.
- Reset mid-W: assert `pad_cpu_rst_b`=0 at beat 5 of a len=15 command → wvalid, busy and done are 0 in the same cycle; after release, `cmd_ready`=1 and a new len=3 command completes correctly.
- Error (macro on): slave returns bresp=2'b10 → `done` pulses, `err`=1 and remains 1 until the next accept clears it.
- Misaligned: src=0x100F → araddr=0x1000.
